// File: rtl/image_matrix_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : image_matrix_3x3_gen
// Purpose  : Builds a bottom-right anchored 3x3 pixel neighbourhood from a
//            raster pixel stream. Two internal line buffers supply the two
//            rows above the current one, and per-row column shift registers
//            supply the two columns to the left. Taps that fall outside the
//            image (top rows / left columns) are either zeroed or replaced
//            by the nearest valid pixel, depending on BORDER_MODE.
// Ports    : clk, rst_n                 - pixel clock, async active-low reset
//            per_frame_vsync/href       - input frame/line sync
//            per_image_clken/data       - input pixel strobe and pixel
//            matrix_frame_vsync/href    - syncs delayed by 2 clocks
//            matrix_image_clken         - window valid strobe (2 clk latency)
//            matrix_p11..matrix_p33     - window taps, p33 = current pixel
//            matrix_border              - window holds a substituted tap
// Revision : 1.0 - initial release
// ============================================================================
module image_matrix_3x3_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int CNT_WIDTH   = 11,
  parameter int BORDER_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_image_clken,
  input  logic [DATA_WIDTH-1:0] per_image_data,
  output logic                  matrix_frame_vsync,
  output logic                  matrix_frame_href,
  output logic                  matrix_image_clken,
  output logic [DATA_WIDTH-1:0] matrix_p11,
  output logic [DATA_WIDTH-1:0] matrix_p12,
  output logic [DATA_WIDTH-1:0] matrix_p13,
  output logic [DATA_WIDTH-1:0] matrix_p21,
  output logic [DATA_WIDTH-1:0] matrix_p22,
  output logic [DATA_WIDTH-1:0] matrix_p23,
  output logic [DATA_WIDTH-1:0] matrix_p31,
  output logic [DATA_WIDTH-1:0] matrix_p32,
  output logic [DATA_WIDTH-1:0] matrix_p33,
  output logic                  matrix_border
);

  localparam int                   ADDR_W   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_HDISP - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_VDISP - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic                  vsync_prev;
  logic                  vsync_rise;
  logic [CNT_WIDTH-1:0]  col, row;
  logic [CNT_WIDTH-1:0]  col_cur, row_cur;
  logic [ADDR_W-1:0]     lb_addr;
  logic [DATA_WIDTH-1:0] lb1 [0:IMG_HDISP-1];
  logic [DATA_WIDTH-1:0] lb2 [0:IMG_HDISP-1];
  logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
  logic [1:0]            vsync_dly, href_dly;

  // win[x][y]: x = 0 is row r-2 .. x = 2 is row r; y = 2 is column c
  logic [DATA_WIDTH-1:0] win     [0:2][0:2];
  logic [DATA_WIDTH-1:0] rsel    [0:2][0:2];
  logic [DATA_WIDTH-1:0] tap     [0:2][0:2];
  logic [DATA_WIDTH-1:0] out_tap [0:2][0:2];

  // Border position of the pixel held in the window stage
  logic s1_valid, s1_row0, s1_row1, s1_col0, s1_col1;

  // A vsync edge re-indexes the pixel arriving in the same cycle to (0,0)
  assign vsync_rise = per_frame_vsync & ~vsync_prev;
  assign col_cur    = vsync_rise ? '0 : col;
  assign row_cur    = vsync_rise ? '0 : row;
  assign lb_addr    = col_cur[ADDR_W-1:0];
  assign lb1_rd     = lb1[lb_addr];
  assign lb2_rd     = lb2[lb_addr];

  // Line buffers: read-before-write, so L1 cascades its old entry into L2.
  // Not reset; stale contents only ever reach taps that get substituted.
  always_ff @(posedge clk) begin
    if (per_image_clken) begin
      lb1[lb_addr] <= per_image_data;
      lb2[lb_addr] <= lb1_rd;
    end
  end

  // Border substitution: first choose a source row per window row, then a
  // source column within it, so corners resolve to the nearest valid pixel.
  always_comb begin
    for (int x = 0; x < 3; x++) begin
      for (int y = 0; y < 3; y++) begin
        rsel[x][y] = win[x][y];
        tap[x][y]  = '0;
      end
    end
    for (int y = 0; y < 3; y++) begin
      if (BORDER_MODE == 1) begin
        if (s1_row0) begin
          rsel[0][y] = win[2][y];
          rsel[1][y] = win[2][y];
        end else if (s1_row1) begin
          rsel[0][y] = win[1][y];
        end
      end else begin
        if (s1_row0 || s1_row1) rsel[0][y] = '0;
        if (s1_row0)            rsel[1][y] = '0;
      end
    end
    for (int x = 0; x < 3; x++) begin
      tap[x][2] = rsel[x][2];
      tap[x][1] = rsel[x][1];
      tap[x][0] = rsel[x][0];
      if (s1_col0) begin
        tap[x][1] = (BORDER_MODE == 1) ? rsel[x][2] : '0;
        tap[x][0] = (BORDER_MODE == 1) ? rsel[x][2] : '0;
      end else if (s1_col1) begin
        tap[x][0] = (BORDER_MODE == 1) ? rsel[x][1] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev         <= 1'b0;
      col                <= '0;
      row                <= '0;
      vsync_dly          <= '0;
      href_dly           <= '0;
      s1_valid           <= 1'b0;
      s1_row0            <= 1'b0;
      s1_row1            <= 1'b0;
      s1_col0            <= 1'b0;
      s1_col1            <= 1'b0;
      matrix_image_clken <= 1'b0;
      matrix_border      <= 1'b0;
      for (int x = 0; x < 3; x++) begin
        for (int y = 0; y < 3; y++) begin
          win[x][y]     <= '0;
          out_tap[x][y] <= '0;
        end
      end
    end else begin
      vsync_prev <= per_frame_vsync;
      vsync_dly  <= {vsync_dly[0], per_frame_vsync};
      href_dly   <= {href_dly[0], per_frame_href};

      // Stage 1: position counters, column shift, border flags
      if (per_image_clken) begin
        if (col_cur == COL_LAST) begin
          col <= '0;
          row <= (row_cur == ROW_LAST) ? '0 : row_cur + ONE;
        end else begin
          col <= col_cur + ONE;
          row <= row_cur;
        end
        for (int x = 0; x < 3; x++) begin
          win[x][0] <= win[x][1];
          win[x][1] <= win[x][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= per_image_data;
        s1_row0   <= (row_cur == '0);
        s1_row1   <= (row_cur == ONE);
        s1_col0   <= (col_cur == '0);
        s1_col1   <= (col_cur == ONE);
      end else if (vsync_rise) begin
        col <= '0;
        row <= '0;
      end
      s1_valid <= per_image_clken;

      // Stage 2: registered window; holds while no new pixel arrives
      matrix_image_clken <= s1_valid;
      if (s1_valid) begin
        for (int x = 0; x < 3; x++) begin
          for (int y = 0; y < 3; y++) begin
            out_tap[x][y] <= tap[x][y];
          end
        end
        matrix_border <= s1_row0 | s1_row1 | s1_col0 | s1_col1;
      end
    end
  end

  assign matrix_frame_vsync = vsync_dly[1];
  assign matrix_frame_href  = href_dly[1];
  assign matrix_p11 = out_tap[0][0];
  assign matrix_p12 = out_tap[0][1];
  assign matrix_p13 = out_tap[0][2];
  assign matrix_p21 = out_tap[1][0];
  assign matrix_p22 = out_tap[1][1];
  assign matrix_p23 = out_tap[1][2];
  assign matrix_p31 = out_tap[2][0];
  assign matrix_p32 = out_tap[2][1];
  assign matrix_p33 = out_tap[2][2];

endmodule
`default_nettype wire

// File: tb/tb_image_matrix_3x3_gen.sv
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_image_matrix_3x3_gen
// Purpose  : Self-checking bench for image_matrix_3x3_gen. One instance per
//            border mode shares the same stimulus; a reference model built
//            on a stored image predicts every window, and a table holds the
//            hand-derived windows for selected positions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_matrix_3x3_gen;

  localparam int H = 4;
  localparam int V = 4;

  typedef struct {
    int          r;
    int          c;
    logic [71:0] e0;
    logic [71:0] e1;
    logic        bd;
    int          due;
    bit          cap;
    int          tag;
  } exp_t;

  typedef struct {
    int          mode;
    int          r;
    int          c;
    logic [71:0] exp;
    logic        bd;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [7:0] d = 8'h00;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  wire [71:0] w0, w1;
  wire        vs0, hr0, cl0, bd0, vs1, hr1, cl1, bd1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  image_matrix_3x3_gen #(.DATA_WIDTH(8), .IMG_HDISP(H), .IMG_VDISP(V),
                         .CNT_WIDTH(11), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr),
    .per_image_clken(ck), .per_image_data(d),
    .matrix_frame_vsync(vs0), .matrix_frame_href(hr0), .matrix_image_clken(cl0),
    .matrix_p11(w0[7:0]),   .matrix_p12(w0[15:8]),  .matrix_p13(w0[23:16]),
    .matrix_p21(w0[31:24]), .matrix_p22(w0[39:32]), .matrix_p23(w0[47:40]),
    .matrix_p31(w0[55:48]), .matrix_p32(w0[63:56]), .matrix_p33(w0[71:64]),
    .matrix_border(bd0));

  image_matrix_3x3_gen #(.DATA_WIDTH(8), .IMG_HDISP(H), .IMG_VDISP(V),
                         .CNT_WIDTH(11), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr),
    .per_image_clken(ck), .per_image_data(d),
    .matrix_frame_vsync(vs1), .matrix_frame_href(hr1), .matrix_image_clken(cl1),
    .matrix_p11(w1[7:0]),   .matrix_p12(w1[15:8]),  .matrix_p13(w1[23:16]),
    .matrix_p21(w1[31:24]), .matrix_p22(w1[39:32]), .matrix_p23(w1[47:40]),
    .matrix_p31(w1[55:48]), .matrix_p32(w1[63:56]), .matrix_p33(w1[71:64]),
    .matrix_border(bd1));

  // ---------------- reference model ----------------
  logic [7:0]  img [0:V-1][0:H-1];
  int          mr = 0, mc = 0;
  logic        pvs = 1'b0;
  exp_t        sbq[$];
  logic [71:0] cap0 [0:H*V-1];
  logic [71:0] cap1 [0:H*V-1];
  logic        capb0 [0:H*V-1];
  logic        capb1 [0:H*V-1];
  logic [71:0] tw0 [0:3];
  logic [71:0] tw1 [0:3];
  logic        tb0 [0:3];
  logic        tb1 [0:3];

  function automatic logic [71:0] mk9(input logic [7:0] a, b, c, e, f, g, h, i, j);
    return {j, i, h, g, f, e, c, b, a};
  endfunction

  // Window from the stored image: out-of-image taps are zero (mode 0) or
  // clamped to row/column 0 (mode 1).
  function automatic logic [71:0] model_win(input int mode, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int x = 0; x < 3; x++) begin
      for (int y = 0; y < 3; y++) begin
        int rr, cc;
        rr = r - 2 + x;
        cc = c - 2 + y;
        if (mode == 0) begin
          w[8*(3*x+y) +: 8] = (rr < 0 || cc < 0) ? 8'h00 : img[rr][cc];
        end else begin
          if (rr < 0) rr = 0;
          if (cc < 0) cc = 0;
          w[8*(3*x+y) +: 8] = img[rr][cc];
        end
      end
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model tracks the pixel index alongside.
  task automatic drive(input logic ick, input logic [7:0] id, input logic ivs,
                       input logic ihr, input bit icap, input int itag);
    exp_t e;
    @(posedge clk);
    #1;
    ck = ick; d = id; vs = ivs; hr = ihr;
    if (ivs && !pvs) begin mr = 0; mc = 0; end
    pvs = ivs;
    if (ick) begin
      img[mr][mc] = id;
      e.r = mr; e.c = mc;
      e.e0 = model_win(0, mr, mc);
      e.e1 = model_win(1, mr, mc);
      e.bd = (mr < 2 || mc < 2);
      e.due = cyc + 2;
      e.cap = icap;
      e.tag = itag;
      sbq.push_back(e);
      if (mc == H - 1) begin mc = 0; mr = (mr == V - 1) ? 0 : mr + 1; end
      else mc++;
    end
  endtask

  task automatic pix(input logic [7:0] id, input bit icap);
    drive(1'b1, id, 1'b0, 1'b1, icap, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), vs, 1'b0, 1'b0, 0);
  endtask

  // ---------------- output monitor ----------------
  logic [71:0] last0 = '0, last1 = '0;
  logic        lastb0 = 1'b0, lastb1 = 1'b0;
  logic        vh1 = 1'b0, vh2 = 1'b0, hh1 = 1'b0, hh2 = 1'b0;
  int          hv = 0;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = '0; last1 = '0; lastb0 = 1'b0; lastb1 = 1'b0; hv = 0;
    end else begin
      if (hv >= 2) begin
        chk("vsync_delay", {70'b0, vs0, vs1}, {70'b0, vh2, vh2});
        chk("href_delay",  {70'b0, hr0, hr1}, {70'b0, hh2, hh2});
      end
      vh2 = vh1; vh1 = vs; hh2 = hh1; hh1 = hr;
      if (hv < 2) hv++;
      if (cl0 || cl1) begin
        chk("strobe_pair", {70'b0, cl0, cl1}, 72'd3);
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: got a strobe, expected none (t=%0t)", $time);
        end else begin
          me = sbq.pop_front();
          chk("latency", 72'(cyc), 72'(me.due));
          chk($sformatf("win_m0_r%0d_c%0d", me.r, me.c), w0, me.e0);
          chk($sformatf("win_m1_r%0d_c%0d", me.r, me.c), w1, me.e1);
          chk($sformatf("border_r%0d_c%0d", me.r, me.c), {70'b0, bd0, bd1}, {70'b0, me.bd, me.bd});
          last0 = me.e0; last1 = me.e1; lastb0 = me.bd; lastb1 = me.bd;
          if (me.cap) begin
            cap0[me.r*H+me.c] = w0; cap1[me.r*H+me.c] = w1;
            capb0[me.r*H+me.c] = bd0; capb1[me.r*H+me.c] = bd1;
          end
          if (me.tag != 0) begin
            tw0[me.tag] = w0; tw1[me.tag] = w1; tb0[me.tag] = bd0; tb1[me.tag] = bd1;
          end
        end
      end else begin
        chk("hold_m0", w0, last0);
        chk("hold_m1", w1, last1);
        chk("hold_border", {70'b0, bd0, bd1}, {70'b0, lastb0, lastb1});
        if (sbq.size() != 0 && cyc > sbq[0].due) begin
          me = sbq.pop_front();
          tests++; fails++;
          $display("FAIL missing_strobe: no strobe for pixel r%0d c%0d due at cycle %0d", me.r, me.c, me.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  vec_t vecs [0:6];

  initial begin
    for (int i = 0; i < H*V; i++) begin
      cap0[i] = '1; cap1[i] = '1; capb0[i] = 1'bx; capb1[i] = 1'bx;
    end
    for (int i = 0; i < 4; i++) begin
      tw0[i] = '1; tw1[i] = '1; tb0[i] = 1'bx; tb1[i] = 1'bx;
    end
    vecs[0] = '{0, 2, 2, mk9(8'h80,8'h81,8'h82,8'h90,8'h91,8'h92,8'hA0,8'hA1,8'hA2), 1'b0, "m0_interior_2_2"};
    vecs[1] = '{0, 1, 3, mk9(8'h00,8'h00,8'h00,8'h81,8'h82,8'h83,8'h91,8'h92,8'h93), 1'b1, "m0_top_1_3"};
    vecs[2] = '{0, 0, 0, mk9(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h80), 1'b1, "m0_corner_0_0"};
    vecs[3] = '{1, 0, 1, mk9(8'h80,8'h80,8'h81,8'h80,8'h80,8'h81,8'h80,8'h80,8'h81), 1'b1, "m1_top_0_1"};
    vecs[4] = '{1, 1, 0, mk9(8'h80,8'h80,8'h80,8'h80,8'h80,8'h80,8'h90,8'h90,8'h90), 1'b1, "m1_left_1_0"};
    vecs[5] = '{1, 2, 2, mk9(8'h80,8'h81,8'h82,8'h90,8'h91,8'h92,8'hA0,8'hA1,8'hA2), 1'b0, "m1_interior_2_2"};
    vecs[6] = '{1, 3, 1, mk9(8'h90,8'h90,8'h91,8'hA0,8'hA0,8'hA1,8'hB0,8'hB0,8'hB1), 1'b1, "m1_left_3_1"};

    // Power-on reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {w0[61:0], w1, bd0, bd1, cl0, cl1, vs0, vs1, hr0, hr1},
        72'd0);
    #2 rst_n = 1'b1;

    // Frame A: gapless, reference data, captured for the table
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        pix(8'(8'h80 + 16*r + c), 1'b1);
    idle(4);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].mode == 0) begin
        chk({vecs[i].name, "_win"}, cap0[vecs[i].r*H+vecs[i].c], vecs[i].exp);
        chk({vecs[i].name, "_border"}, {71'b0, capb0[vecs[i].r*H+vecs[i].c]}, {71'b0, vecs[i].bd});
      end else begin
        chk({vecs[i].name, "_win"}, cap1[vecs[i].r*H+vecs[i].c], vecs[i].exp);
        chk({vecs[i].name, "_border"}, {71'b0, capb1[vecs[i].r*H+vecs[i].c]}, {71'b0, vecs[i].bd});
      end
    end

    // Frame B: reference data with random idle gaps
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        pix(8'(8'h80 + 16*r + c), 1'b0);
        idle($urandom_range(0, 5));
      end
    // Frame C: random data with random gaps
    for (int i = 0; i < H*V; i++) begin
      pix(8'($urandom), 1'b0);
      idle($urandom_range(0, 5));
    end

    // vsync edge together with the pixel after (1,2)
    for (int i = 0; i < 7; i++) pix(8'($urandom), 1'b0);
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1);
    drive(1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) pix(8'($urandom), 1'b0);
    // vsync edge during an idle cycle also restarts indexing
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 9; i++) pix(8'($urandom), 1'b0);
    idle(4);
    chk("vsync_restart_m0", tw0[1], mk9(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h5A));
    chk("vsync_restart_m1", tw1[1], mk9(8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A,8'h5A));
    chk("vsync_restart_border", {70'b0, tb0[1], tb1[1]}, 72'd3);

    // Reset pulsed mid-frame, right after a pixel was accepted
    for (int i = 0; i < 6; i++) pix(8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {w0[61:0], w1, bd0, bd1, cl0, cl1, vs0, vs1, hr0, hr1},
        72'd0);
    sbq.delete();
    mr = 0; mc = 0; pvs = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 2);
    for (int i = 0; i < 5; i++) pix(8'($urandom), 1'b0);
    idle(4);
    chk("post_reset_m0", tw0[2], mk9(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h3C));
    chk("post_reset_m1", tw1[2], mk9(8'h3C,8'h3C,8'h3C,8'h3C,8'h3C,8'h3C,8'h3C,8'h3C,8'h3C));
    chk("post_reset_border", {70'b0, tb0[2], tb1[2]}, 72'd3);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d windows outstanding, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/image_matrix_3x3_gen.md
Name: image_matrix_3x3_gen

Overview:
Parametrised successor to the 3x3 window generator. It builds a 3x3 neighbourhood from a raster pixel stream, with configurable pixel width and image size. Line buffers are internal RAM arrays, and row/column tracking is frame-synchronised. Border handling (zero-pad or replicate) is selectable. It sits between the pixel pre-processing stage and the 3x3 kernel blocks (Sobel, median, erosion/dilation).

Parameters:
DATA_WIDTH, 8, pixel bit width
IMG_HDISP, 640, active pixels per line (line-buffer depth)
IMG_VDISP, 480, active lines per frame
CNT_WIDTH, 11, width of internal row/column counters (must hold max(IMG_HDISP, IMG_VDISP)-1)
BORDER_MODE, 0, 0 = missing taps forced to zero; 1 = missing taps replicate nearest valid pixel

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
per_frame_vsync  input  1  frame sync; rising edge marks frame start
per_frame_href  input  1  line valid, delayed only
per_image_clken  input  1  input pixel strobe, one pixel per high cycle
per_image_data  input  DATA_WIDTH  input pixel
matrix_frame_vsync  output  1  per_frame_vsync delayed 2 cycles
matrix_frame_href  output  1  per_frame_href delayed 2 cycles
matrix_image_clken  output  1  window valid strobe
matrix_p11..matrix_p33  output  DATA_WIDTH each (9 ports)  window; p33 = current pixel (r,c), p11 = (r-2,c-2), pXY = row r-3+X, col c-3+Y
matrix_border  output  1  high when the window contains a substituted tap (r<2 or c<2)

Behaviour:
- Reset (async, rst_n low): all outputs 0, counters 0, delay lines 0. Line-buffer RAM contents are not reset; the border logic masks stale data.
- Counters:
  - col increments on each per_image_clken; at IMG_HDISP-1 it wraps to 0 and row increments.
  - row wraps at IMG_VDISP-1 to 0, so surplus pixels start a new frame.
- Frame sync: a rising edge of per_frame_vsync (registered compare) clears row/col. If the edge and per_image_clken are in the same cycle, that pixel is (0,0).
- Line buffers: two RAMs, depth IMG_HDISP, addressed by col. On clken, read-before-write:
  - L1[col] gives row r-1; L2[col] gives row r-2.
  - Then L1[col] <= data and L2[col] <= old L1[col].
- Column shift: per row, a 3-deep shift register advances only on clken.
- Latency: exactly 2 clk from per_image_clken to matrix_image_clken. All nine taps, matrix_border, vsync and href are aligned to that strobe. One output strobe per accepted pixel; idle gaps of any length are allowed with no change in values.
- Outputs hold their last value when matrix_image_clken is low.
- Border substitution (applied per tap):
  - Mode 0: row index <0 or col index <0 gives 0.
  - Mode 1, rows: r=0 takes rows r-1 and r-2 from row r; r=1 takes row r-2 from row r-1.
  - Mode 1, columns: c=0 takes cols c-1 and c-2 from col c; c=1 takes col c-2 from col c-1.
  - Row and column substitution compose: the corner takes the nearest valid pixel.
- No right/bottom border handling: the window is bottom-right anchored, so those neighbours always exist.
- Reset mid-frame: immediate clear; the first pixel after release is (0,0) with border=1.

Test Plan:
(Common setup: IMG_HDISP=4, IMG_VDISP=4; data = 0x80 + 16*r + c; continuous clken unless stated.)
- Mode 0, interior pixel (2,2)=0xA2 -> 2 cycles later: p11..p13=80,81,82; p21..p23=90,91,92; p31..p33=A0,A1,A2; border=0.
- Mode 0, pixel (1,3)=0x93 -> p1x=00,00,00; p2x=81,82,83; p3x=91,92,93; border=1. Pixel (0,0) -> only p33=80, the other taps 00.
- Mode 1, pixel (0,1)=0x81 -> every row reads 80,80,81; border=1. Pixel (1,0)=0x90 -> rows 80,80,80 / 80,80,80 / 90,90,90.
- Random clken gaps (0-5 idle cycles) over a full frame -> 16 output strobes; windows identical to the gapless run; each strobe exactly 2 cycles after its input.
- vsync rising edge after pixel (1,2) -> next pixel indexed (0,0): border=1, mode 0 neighbours all 00. rst_n pulsed low mid-frame -> outputs 0 the same cycle; first post-reset pixel treated as (0,0).
